// File: rtl/ncl_pkg.sv
// Shared NCL dual-rail helpers: rail code decode and TH22 hysteresis next-state.
// Ports: none (package). Provides rail_t, th22_next(), rail_decode().
// Used by the register stage and anything else that reasons about dual-rail codes.
package ncl_pkg;

    // Two-bit dual-rail code, packed as {true_rail, false_rail}.
    typedef enum logic [1:0] {
        NULL    = 2'b00,
        DATA0   = 2'b01,
        DATA1   = 2'b10,
        ILLEGAL = 2'b11
    } rail_t;

    // TH22 with hysteresis: output follows the inputs only when they agree,
    // otherwise it remembers its previous value.
    function automatic logic th22_next(input logic cur, input logic a, input logic b);
        logic nxt;
        nxt = cur;
        if (a && b) begin
            nxt = 1'b1;
        end else if (!a && !b) begin
            nxt = 1'b0;
        end
        return nxt;
    endfunction

    function automatic rail_t rail_decode(input logic t, input logic f);
        return rail_t'({t, f});
    endfunction

endpackage

// File: rtl/ncl_dr_reg_stage_thnn_hyst.sv
// N-input THnn hysteresis gate, registered: N-input form of the 3-input resettable gate.
// Ports: clk, rst (async, active-high), in[N] inputs, y registered output.
// y rises when every input is 1, falls when every input is 0, otherwise holds.
module thnn_hyst #(
    parameter int N       = 3,
    parameter bit RST_VAL = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in,
    output logic         y
);

    logic all_set;
    logic all_clr;

    assign all_set = &in;
    assign all_clr = ~|in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y <= RST_VAL;
        end else if (all_set) begin
            y <= 1'b1;
        end else if (all_clr) begin
            y <= 1'b0;
        end
    end

endmodule

// File: rtl/ncl_dr_reg_stage.sv
// Dual-rail NCL register stage: per-rail TH22 latches gated by ki, THnn completion tree
// driving ko, sticky illegal-code flag and DATA wavefront counter.
// Ports: clk, rst, d_t/d_f in, ki in, q_t/q_f out, ko out, err out, wf_cnt out.
// Latency: d/ki -> q 1 cycle, q -> ko 1 cycle (2 cycles input to ko).
module ncl_dr_reg_stage
    import ncl_pkg::*;
#(
    parameter int           W        = 4,
    parameter bit           RST_DATA = 1'b0,
    parameter logic [W-1:0] RST_VAL  = '0,
    parameter int           CW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  d_t,
    input  logic [W-1:0]  d_f,
    input  logic          ki,
    output logic [W-1:0]  q_t,
    output logic [W-1:0]  q_f,
    output logic          ko,
    output logic          err,
    output logic [CW-1:0] wf_cnt
);

    logic [W-1:0] comp;
    logic [W-1:0] in_illegal;
    logic [W-1:0] q_illegal;
    logic         tree_y;
    logic         tree_rise;

    // Per-bit rail latches. Each rail is an independent TH22 of (d_x, ki), so an
    // illegal input code is latched exactly like a legal one; err only reports it.
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
        localparam logic RST_T = RST_DATA & RST_VAL[gi];
        localparam logic RST_F = RST_DATA & ~RST_VAL[gi];

        logic rail_t_q;
        logic rail_f_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rail_t_q <= RST_T;
                rail_f_q <= RST_F;
            end else begin
                rail_t_q <= th22_next(rail_t_q, d_t[gi], ki);
                rail_f_q <= th22_next(rail_f_q, d_f[gi], ki);
            end
        end

        assign q_t[gi]        = rail_t_q;
        assign q_f[gi]        = rail_f_q;
        assign comp[gi]       = rail_t_q | rail_f_q;
        assign in_illegal[gi] = (rail_decode(d_t[gi], d_f[gi]) == ILLEGAL);
        assign q_illegal[gi]  = (rail_decode(rail_t_q, rail_f_q) == ILLEGAL);
    end

    // Completion tree: tree_y=1 means the stage holds a complete DATA wavefront.
    thnn_hyst #(
        .N       (W),
        .RST_VAL (RST_DATA)
    ) u_tree (
        .clk (clk),
        .rst (rst),
        .in  (comp),
        .y   (tree_y)
    );

    assign ko = ~tree_y;

    // Same condition that makes the tree rise on this edge, so the counter and
    // ko change together (counter wrap therefore shows 0 on the completing edge).
    assign tree_rise = ~tree_y & (&comp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wf_cnt <= '0;
        end else if (tree_rise) begin
            wf_cnt <= wf_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if ((|in_illegal) || (|q_illegal)) begin
            err <= 1'b1;
        end
    end

endmodule
